// File: rtl/invader_formation.sv
// Formation controller for a row of invaders: marches the row with bounce-and-drop,
// resolves player-projectile hits per invader, flies one enemy projectile per
// invader, and keeps score, wave number and landing status.
module invader_formation #(
  parameter int N_INV      = 5,
  parameter int SPACING    = 40,
  parameter int X_MIN      = 96,
  parameter int X_MAX      = 389,
  parameter int X_START    = 220,
  parameter int Y_START    = 50,
  parameter int Y_STEP     = 10,
  parameter int MOVE_DIV   = 2,
  parameter int FIRE_DIV   = 8,
  parameter int HIT_DX     = 15,
  parameter int HIT_H      = 20,
  parameter int PROJ_SPEED = 1,
  parameter int Y_LIMIT    = 480,
  parameter int BOTTOM_Y   = 400,
  parameter int POINTS     = 10,
  parameter int GAP_TICKS  = 64
) (
  input  logic                 dclk,
  input  logic                 clr,
  input  logic                 tick,
  input  logic                 play,
  input  logic                 proj_valid,
  input  logic [9:0]           proj_x,
  input  logic [9:0]           proj_y,
  input  logic [N_INV-1:0]     destroy,
  output logic [9:0]           enemy_x,
  output logic [9:0]           enemy_y,
  output logic [N_INV-1:0]     alive,
  output logic [N_INV-1:0]     eproj_active,
  output logic [10*N_INV-1:0]  eproj_x,
  output logic [10*N_INV-1:0]  eproj_y,
  output logic                 hit_pulse,
  output logic [2:0]           hit_idx,
  output logic [13:0]          score,
  output logic [3:0]           wave,
  output logic                 wave_clear,
  output logic                 landed
);

  typedef enum logic [1:0] {IDLE, RUN, GAP, LANDED} state_t;
  state_t state, state_nxt;

  localparam logic signed [10:0] HDX = 11'(HIT_DX);
  localparam logic [9:0]         HH  = 10'(HIT_H);
  localparam logic [N_INV-1:0]   ONE = 1;

  logic [15:0]              move_cnt, fire_cnt, gap_cnt;
  logic                     dir_right;
  logic [10:0]              cx [N_INV];
  logic signed [10:0]       dx [N_INV];
  logic [N_INV-1:0]         match, kill_mask;
  logic                     hit_any;
  logic [2:0]               hit_sel;
  logic                     land_now, run_tick, fly_tick;
  logic                     do_march, do_fire, do_kill, last_kill, gap_done;

  // Score accumulates and sticks at the 14-bit ceiling.
  function automatic logic [13:0] sat_score(input logic [13:0] s);
    logic [14:0] t;
    t = {1'b0, s} + 15'(POINTS);
    return (t > 15'd16383) ? 14'd16383 : t[13:0];
  endfunction

  // Wave counter stops at 15 rather than wrapping.
  function automatic logic [3:0] sat_wave(input logic [3:0] w);
    return (w == 4'd15) ? w : w + 4'd1;
  endfunction

  // Per-invader hit box against the pre-move formation; lowest index wins.
  always_comb begin
    hit_any = 1'b0;
    hit_sel = '0;
    for (int i = 0; i < N_INV; i++) begin
      cx[i]    = 11'(enemy_x) + 11'(i * SPACING);
      dx[i]    = $signed({1'b0, proj_x}) - $signed(cx[i]);
      match[i] = proj_valid && alive[i] && (proj_y > enemy_y) &&
                 ((proj_y - enemy_y) < HH) && (dx[i] < HDX) && (dx[i] > -HDX);
    end
    for (int i = N_INV - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit_any = 1'b1;
        hit_sel = 3'(i);
      end
    end
  end

  assign kill_mask = ONE << hit_sel;
  assign land_now  = ({1'b0, enemy_y} + 11'(HIT_H)) >= 11'(BOTTOM_Y);

  // State register.
  always_ff @(posedge dclk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; play low forces IDLE on any cycle.
  always_comb begin
    state_nxt = state;
    if (!play) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = RUN;
        RUN: begin
          if (tick && land_now) state_nxt = LANDED;
          else if (last_kill)   state_nxt = GAP;
        end
        GAP:     if (gap_done) state_nxt = RUN;
        LANDED:  state_nxt = LANDED;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Per-tick action strobes decoded from the current state.
  always_comb begin
    run_tick  = tick && (state == RUN) && !land_now;
    fly_tick  = tick && ((state == RUN) || (state == LANDED));
    do_march  = run_tick && (move_cnt == 16'(MOVE_DIV - 1));
    do_fire   = run_tick && (fire_cnt == 16'(FIRE_DIV - 1));
    do_kill   = run_tick && hit_any;
    last_kill = do_kill && ((alive & ~kill_mask) == '0);
    gap_done  = tick && (state == GAP) && (gap_cnt == 16'(GAP_TICKS - 1));
  end

  // Formation, projectile, score and wave registers.
  always_ff @(posedge dclk or negedge clr) begin
    if (!clr) begin
      enemy_x      <= 10'(X_START);
      enemy_y      <= 10'(Y_START);
      dir_right    <= 1'b1;
      alive        <= '1;
      eproj_active <= '0;
      eproj_x      <= '0;
      eproj_y      <= '0;
      hit_pulse    <= 1'b0;
      hit_idx      <= '0;
      score        <= '0;
      wave         <= '0;
      wave_clear   <= 1'b0;
      landed       <= 1'b0;
      move_cnt     <= '0;
      fire_cnt     <= '0;
      gap_cnt      <= '0;
    end else if (!play) begin
      enemy_x      <= 10'(X_START);
      enemy_y      <= 10'(Y_START);
      dir_right    <= 1'b1;
      alive        <= '1;
      eproj_active <= '0;
      eproj_x      <= '0;
      eproj_y      <= '0;
      hit_pulse    <= 1'b0;
      hit_idx      <= '0;
      score        <= '0;
      wave         <= '0;
      wave_clear   <= 1'b0;
      landed       <= 1'b0;
      move_cnt     <= '0;
      fire_cnt     <= '0;
      gap_cnt      <= '0;
    end else begin
      hit_pulse  <= 1'b0;
      wave_clear <= 1'b0;

      if (tick && (state == RUN) && land_now) landed <= 1'b1;

      if (run_tick) begin
        move_cnt <= do_march ? '0 : move_cnt + 16'd1;
        fire_cnt <= do_fire  ? '0 : fire_cnt + 16'd1;
      end

      // A step at the active edge limit becomes a drop plus direction flip.
      if (do_march) begin
        if ((dir_right && enemy_x == 10'(X_MAX)) || (!dir_right && enemy_x == 10'(X_MIN))) begin
          enemy_y   <= enemy_y + 10'(Y_STEP);
          dir_right <= !dir_right;
        end else if (dir_right) begin
          enemy_x <= enemy_x + 10'd1;
        end else begin
          enemy_x <= enemy_x - 10'd1;
        end
      end

      // Active channels fly or retire; idle channels may launch from their invader.
      for (int i = 0; i < N_INV; i++) begin
        if (fly_tick && eproj_active[i]) begin
          if (destroy[i] || (({1'b0, eproj_y[10*i +: 10]} + 11'(PROJ_SPEED)) >= 11'(Y_LIMIT))) begin
            eproj_active[i]     <= 1'b0;
            eproj_x[10*i +: 10] <= '0;
            eproj_y[10*i +: 10] <= '0;
          end else begin
            eproj_y[10*i +: 10] <= eproj_y[10*i +: 10] + 10'(PROJ_SPEED);
          end
        end else if (do_fire && alive[i] && !eproj_active[i]) begin
          eproj_active[i]     <= 1'b1;
          eproj_x[10*i +: 10] <= cx[i][9:0];
          eproj_y[10*i +: 10] <= enemy_y + HH;
        end
      end

      if (do_kill) begin
        alive     <= alive & ~kill_mask;
        hit_pulse <= 1'b1;
        hit_idx   <= hit_sel;
        score     <= sat_score(score);
      end

      // Clearing the row wipes every enemy projectile before the pause.
      if (last_kill) begin
        wave_clear   <= 1'b1;
        eproj_active <= '0;
        eproj_x      <= '0;
        eproj_y      <= '0;
      end

      if (tick && (state == GAP)) gap_cnt <= gap_done ? '0 : gap_cnt + 16'd1;

      if (gap_done) begin
        enemy_x   <= 10'(X_START);
        enemy_y   <= 10'(Y_START);
        dir_right <= 1'b1;
        alive     <= '1;
        wave      <= sat_wave(wave);
        move_cnt  <= '0;
        fire_cnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_invader_formation.sv
// Bench for invader_formation: directed sequences and a hit-vector table, plus
// randomized play checked every cycle against a rule-level reference model.
module tb_invader_formation;

  localparam int N = 5;
  localparam int SPACING = 40, X_MIN = 96, X_MAX = 389, X_START = 220, Y_START = 50;
  localparam int Y_STEP = 10, MOVE_DIV = 2, FIRE_DIV = 8, HIT_DX = 15, HIT_H = 20;
  localparam int PROJ_SPEED = 1, Y_LIMIT = 480, BOTTOM_Y = 400, POINTS = 10, GAP_TICKS = 64;
  localparam int PH_IDLE = 0, PH_RUN = 1, PH_GAP = 2, PH_LAND = 3;

  logic             dclk = 1'b0;
  logic             clr, tick, play, proj_valid;
  logic [9:0]       proj_x, proj_y;
  logic [N-1:0]     destroy;
  logic [9:0]       enemy_x, enemy_y;
  logic [N-1:0]     alive, eproj_active;
  logic [10*N-1:0]  eproj_x, eproj_y;
  logic             hit_pulse, wave_clear, landed;
  logic [2:0]       hit_idx;
  logic [13:0]      score;
  logic [3:0]       wave;

  invader_formation #(.N_INV(N)) dut (
    .dclk(dclk), .clr(clr), .tick(tick), .play(play), .proj_valid(proj_valid),
    .proj_x(proj_x), .proj_y(proj_y), .destroy(destroy),
    .enemy_x(enemy_x), .enemy_y(enemy_y), .alive(alive), .eproj_active(eproj_active),
    .eproj_x(eproj_x), .eproj_y(eproj_y), .hit_pulse(hit_pulse), .hit_idx(hit_idx),
    .score(score), .wave(wave), .wave_clear(wave_clear), .landed(landed)
  );

  always #5 dclk = ~dclk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int m_phase, m_x, m_y, m_score, m_wave, m_runt, m_gapt, m_hidx;
  bit m_right, m_hit, m_wc, m_landed;
  bit m_alive [N];
  bit m_act [N];
  int m_ex [N];
  int m_ey [N];

  typedef struct { int idx; int dx; int dy; bit exp_hit; int exp_idx; } hit_vec_t;
  hit_vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = PH_IDLE; m_x = X_START; m_y = Y_START; m_right = 1'b1;
    m_score = 0; m_wave = 0; m_runt = 0; m_gapt = 0; m_hidx = 0;
    m_hit = 1'b0; m_wc = 1'b0; m_landed = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_alive[i] = 1'b1; m_act[i] = 1'b0; m_ex[i] = 0; m_ey[i] = 0;
    end
  endtask

  task automatic model_fly();
    for (int i = 0; i < N; i++) begin
      if (m_act[i]) begin
        if (destroy[i] || m_ey[i] + PROJ_SPEED >= Y_LIMIT) begin
          m_act[i] = 1'b0; m_ex[i] = 0; m_ey[i] = 0;
        end else begin
          m_ey[i] += PROJ_SPEED;
        end
      end
    end
  endtask

  // One dclk cycle of game rules, using the inputs present at that edge.
  task automatic model_cycle();
    int hi, ox, oy, px, py, d;
    bit pre_alive [N];
    bit pre_act [N];
    bit any;
    m_hit = 1'b0;
    m_wc  = 1'b0;
    if (!clr || !play) begin
      model_reset();
      return;
    end
    case (m_phase)
      PH_IDLE: m_phase = PH_RUN;
      PH_RUN: if (tick) begin
        if (m_y + HIT_H >= BOTTOM_Y) begin
          m_phase = PH_LAND; m_landed = 1'b1;
          model_fly();
        end else begin
          hi = -1; ox = m_x; oy = m_y; px = int'(proj_x); py = int'(proj_y);
          for (int i = 0; i < N; i++) begin
            pre_alive[i] = m_alive[i];
            pre_act[i]   = m_act[i];
            d = px - (ox + i * SPACING);
            if (d < 0) d = -d;
            if (hi < 0 && proj_valid && m_alive[i] && py > oy && py - oy < HIT_H && d < HIT_DX) hi = i;
          end
          m_runt++;
          if (m_runt % MOVE_DIV == 0) begin
            if ((m_right && m_x == X_MAX) || (!m_right && m_x == X_MIN)) begin
              m_y += Y_STEP; m_right = !m_right;
            end else begin
              m_x += m_right ? 1 : -1;
            end
          end
          model_fly();
          if (m_runt % FIRE_DIV == 0) begin
            for (int i = 0; i < N; i++) begin
              if (pre_alive[i] && !pre_act[i]) begin
                m_act[i] = 1'b1; m_ex[i] = ox + i * SPACING; m_ey[i] = oy + HIT_H;
              end
            end
          end
          if (hi >= 0) begin
            m_alive[hi] = 1'b0; m_hit = 1'b1; m_hidx = hi;
            m_score = (m_score + POINTS > 16383) ? 16383 : m_score + POINTS;
            any = 1'b0;
            for (int i = 0; i < N; i++) any |= m_alive[i];
            if (!any) begin
              m_wc = 1'b1; m_phase = PH_GAP; m_gapt = 0;
              for (int i = 0; i < N; i++) begin
                m_act[i] = 1'b0; m_ex[i] = 0; m_ey[i] = 0;
              end
            end
          end
        end
      end
      PH_GAP: if (tick) begin
        m_gapt++;
        if (m_gapt == GAP_TICKS) begin
          m_x = X_START; m_y = Y_START; m_right = 1'b1; m_runt = 0;
          for (int i = 0; i < N; i++) m_alive[i] = 1'b1;
          m_wave = (m_wave == 15) ? 15 : m_wave + 1;
          m_phase = PH_RUN;
        end
      end
      default: if (tick) model_fly();
    endcase
  endtask

  task automatic check_all();
    logic [N-1:0] ea, ep;
    logic [10*N-1:0] ex, ey;
    for (int i = 0; i < N; i++) begin
      ea[i] = m_alive[i]; ep[i] = m_act[i];
      ex[10*i +: 10] = 10'(m_ex[i]); ey[10*i +: 10] = 10'(m_ey[i]);
    end
    chk("enemy_x", 64'(enemy_x), 64'(m_x));
    chk("enemy_y", 64'(enemy_y), 64'(m_y));
    chk("alive", 64'(alive), 64'(ea));
    chk("eproj_active", 64'(eproj_active), 64'(ep));
    chk("eproj_x", 64'(eproj_x), 64'(ex));
    chk("eproj_y", 64'(eproj_y), 64'(ey));
    chk("hit_pulse", 64'(hit_pulse), 64'(m_hit));
    chk("hit_idx", 64'(hit_idx), 64'(m_hidx));
    chk("score", 64'(score), 64'(m_score));
    chk("wave", 64'(wave), 64'(m_wave));
    chk("wave_clear", 64'(wave_clear), 64'(m_wc));
    chk("landed", 64'(landed), 64'(m_landed));
  endtask

  task automatic cyc();
    @(posedge dclk);
    @(negedge dclk);
    model_cycle();
    check_all();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_x"}, 64'(enemy_x), 64'd220);
    chk({tag, "_y"}, 64'(enemy_y), 64'd50);
    chk({tag, "_alive"}, 64'(alive), 64'h1f);
    chk({tag, "_eact"}, 64'(eproj_active), 64'd0);
    chk({tag, "_score"}, 64'(score), 64'd0);
    chk({tag, "_wave"}, 64'(wave), 64'd0);
    chk({tag, "_landed"}, 64'(landed), 64'd0);
  endtask

  initial begin
    int n, lx;
    tbl[0] = '{1,   0,  5, 1'b1, 1};
    tbl[1] = '{1,   0,  5, 1'b0, 0};
    tbl[2] = '{2,  15,  5, 1'b0, 0};
    tbl[3] = '{2, -15,  5, 1'b0, 0};
    tbl[4] = '{2,  14,  5, 1'b1, 2};
    tbl[5] = '{3, -14,  5, 1'b1, 3};
    tbl[6] = '{0,   0,  0, 1'b0, 0};
    tbl[7] = '{0,   0, 20, 1'b0, 0};
    tbl[8] = '{0,   0, 19, 1'b1, 0};
    tbl[9] = '{4,   0,  5, 1'b1, 4};

    clr = 1'b0; play = 1'b0; tick = 1'b0; proj_valid = 1'b0;
    proj_x = '0; proj_y = '0; destroy = '0;
    model_reset();
    repeat (3) @(negedge dclk);
    check_all();
    chk_reset_vals("reset");
    clr = 1'b1;
    cyc();

    // March right to the limit, first volley, destroy, then bounce and drop
    play = 1'b1;
    cyc();
    tick = 1'b1;
    for (int t = 1; t <= 338; t++) begin
      destroy = (t == 9) ? 5'b00100 : 5'b00000;
      cyc();
      if (t == 2) chk("march_first", 64'(enemy_x), 64'd221);
      if (t == 8) begin
        chk("fire_all", 64'(eproj_active), 64'h1f);
        chk("fire_y0", 64'(eproj_y[9:0]), 64'd70);
        chk("fire_x0", 64'(eproj_x[9:0]), 64'd223);
      end
      if (t == 9) chk("destroy_ch2", 64'(eproj_active), 64'h1b);
    end
    destroy = '0;
    chk("march_at_max", 64'(enemy_x), 64'd389);
    cyc(); cyc();
    chk("drop_y", 64'(enemy_y), 64'd60);
    chk("drop_x_hold", 64'(enemy_x), 64'd389);
    cyc(); cyc();
    chk("march_left", 64'(enemy_x), 64'd388);

    // Hit-vector table relative to the current formation
    for (int r = 0; r < 10; r++) begin
      proj_x = 10'(m_x + tbl[r].idx * SPACING + tbl[r].dx);
      proj_y = 10'(m_y + tbl[r].dy);
      proj_valid = 1'b1; tick = 1'b1;
      cyc();
      chk($sformatf("tbl%0d_hit", r), 64'(hit_pulse), 64'(tbl[r].exp_hit));
      if (tbl[r].exp_hit) chk($sformatf("tbl%0d_idx", r), 64'(hit_idx), 64'(tbl[r].exp_idx));
      if (r == 0) begin
        chk("tbl0_alive", 64'(alive), 64'h1d);
        chk("tbl0_score", 64'(score), 64'd10);
      end
      proj_valid = 1'b0; tick = 1'b0;
      cyc();
      chk($sformatf("tbl%0d_pulse_width", r), 64'(hit_pulse), 64'd0);
    end

    // Last kill happened in the final row: check the wave transition
    chk("wclear_alive", 64'(alive), 64'd0);
    chk("wclear_proj", 64'(eproj_active), 64'd0);
    chk("wclear_score", 64'(score), 64'd50);
    chk("wclear_wave_pre", 64'(wave), 64'd0);
    tick = 1'b1;
    repeat (63) cyc();
    chk("gap_hold_alive", 64'(alive), 64'd0);
    cyc();
    chk("gap_x", 64'(enemy_x), 64'd220);
    chk("gap_y", 64'(enemy_y), 64'd50);
    chk("gap_alive", 64'(alive), 64'h1f);
    chk("gap_wave", 64'(wave), 64'd1);

    // Randomized play against the model
    for (int c = 0; c < 3000; c++) begin
      tick = 1'($urandom_range(0, 1));
      play = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      proj_valid = 1'($urandom_range(0, 1));
      proj_x = 10'(m_x + $urandom_range(0, 200) - 20);
      proj_y = 10'(m_y + $urandom_range(0, 30));
      destroy = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      cyc();
    end
    play = 1'b1; proj_valid = 1'b0; destroy = '0;

    // Wave counter saturation: clear 17 waves from a fresh start
    play = 1'b0; tick = 1'b0; cyc();
    play = 1'b1; cyc();
    for (int w = 0; w < 17; w++) begin
      tick = 1'b1;
      for (int k = 0; k < N; k++) begin
        proj_x = 10'(m_x + k * SPACING); proj_y = 10'(m_y + 5); proj_valid = 1'b1;
        cyc();
      end
      proj_valid = 1'b0;
      repeat (GAP_TICKS) cyc();
    end
    chk("wave_sat", 64'(wave), 64'd15);
    chk("wave_sat_score", 64'(score), 64'd850);

    // Drop until the formation lands
    play = 1'b0; tick = 1'b0; cyc();
    play = 1'b1; cyc();
    tick = 1'b1; n = 0;
    while (!m_landed && n < 25000) begin
      cyc();
      n++;
    end
    chk("landed_set", 64'(landed), 64'd1);
    chk("landed_y", 64'(enemy_y), 64'd380);
    lx = m_x;
    repeat (6) cyc();
    chk("landed_x_frozen", 64'(enemy_x), 64'(lx));
    proj_x = 10'(m_x); proj_y = 10'(m_y + 5); proj_valid = 1'b1;
    cyc();
    chk("landed_no_hit", 64'(hit_pulse), 64'd0);
    chk("landed_alive", 64'(alive), 64'h1f);
    proj_valid = 1'b0;

    // play low returns everything to reset values
    play = 1'b0; tick = 1'b0;
    cyc();
    chk_reset_vals("play0");

    // Asynchronous clear mid-run, after a hit
    play = 1'b1; cyc();
    tick = 1'b1;
    repeat (20) cyc();
    proj_x = 10'(m_x); proj_y = 10'(m_y + 5); proj_valid = 1'b1;
    cyc();
    chk("pre_clr_score", 64'(score), 64'd10);
    proj_valid = 1'b0;
    repeat (3) cyc();
    #2 clr = 1'b0;
    #1;
    chk_reset_vals("clr");
    model_reset();
    tick = 1'b0;
    cyc();
    clr = 1'b1;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
